// File: rtl/lock_pkg.sv
// Shared key codes, FSM state encoding and a digit check for the coded-lock key arbiter.
package lock_pkg;

    localparam logic [3:0] KEY_CANCEL  = 4'hA;
    localparam logic [3:0] KEY_CONFIRM = 4'hB;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_STALL = 2'd3;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/lock_rr_arb2.sv
// Two-way round-robin grant for session start; a forced grant lets a preempting source win outright.
module lock_rr_arb2 (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] req,
    input  logic       take,
    input  logic       force_vld,
    input  logic       force_id,
    output logic [1:0] gnt
);

    logic rr_last_q, rr_last_d;

    always_comb begin
        rr_last_d = rr_last_q;
        gnt       = 2'b00;
        if (force_vld) begin
            gnt       = force_id ? 2'b10 : 2'b01;
            rr_last_d = force_id;
        end else if (req == 2'b11) begin
            gnt = rr_last_q ? 2'b01 : 2'b10;
            if (take) begin
                rr_last_d = ~rr_last_q;
            end
        end else begin
            gnt = req;
        end
    end

    // rr_last starts at 1 so that src 0 wins the first contested grant
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/lock_key_arbiter.sv
// Shares the coded-lock key interface between the door keypad (src 0) and the remote panel (src 1).
// Define LOCK_ARB_PREEMPT_EN to let the non-owner end a session with a cancel key and take it over.
//   state | meaning
//   IDLE  | no session; picks an owner from the valid sources
//   OWN   | owner may send one key; idle timeout running
//   GAP   | post-key spacing; returns to OWN (owner kept) or IDLE / preemptor
//   STALL | lock reports open or locked out; nobody is served
module lock_key_arbiter
    import lock_pkg::*;
#(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] s_valid,
    input  logic [7:0] s_key,
    output logic [1:0] s_ready,
    input  logic       unlock_ok,
    input  logic       locking,
    output logic       key_stb,
    output logic [3:0] din,
    output logic       confirm,
    output logic       cancel,
    output logic [1:0] owner,
    output logic       busy
);

    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    // The counter is frozen in GAP, so the gap cycles are credited up front on each digit.
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_CREDIT = (GAP >= TIMEOUT - 1) ? TW'(TIMEOUT - 1) : TW'(GAP);

    logic [1:0]    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    pend_q, pend_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]    din_q, din_d;
    logic          key_stb_q, key_stb_d;
    logic          confirm_q, confirm_d;
    logic          cancel_q, cancel_d;

    logic       stall_in, to_hit, own_rdy, acc_own, acc_pre, go_gap, arb_take;
    logic [3:0] key_own;
    logic [1:0] arb_gnt;

    assign stall_in = unlock_ok | locking;
    assign key_own  = owner_q[1] ? s_key[7:4] : s_key[3:0];
    assign to_hit   = (state_q == ST_OWN) && (to_cnt_q == TO_LAST);
    assign own_rdy  = (state_q == ST_OWN) && !to_hit;
    assign acc_own  = |(s_valid & s_ready & owner_q);
    assign arb_take = (state_q == ST_IDLE) && !stall_in;

`ifdef LOCK_ARB_PREEMPT_EN
    logic [1:0] other;
    logic [3:0] other_key;
    logic       pre_req;

    assign other     = ~owner_q;
    assign other_key = owner_q[1] ? s_key[3:0] : s_key[7:4];
    // The owner's own key wins the single transfer slot over a preempt attempt.
    assign pre_req   = own_rdy && !(|(s_valid & owner_q)) && (|(s_valid & other))
                       && (other_key == KEY_CANCEL);
    assign s_ready   = own_rdy ? (owner_q | (pre_req ? other : 2'b00)) : 2'b00;
    assign acc_pre   = pre_req;
`else
    assign s_ready   = own_rdy ? owner_q : 2'b00;
    assign acc_pre   = 1'b0;
`endif

    lock_rr_arb2 u_arb (
        .clk       (clk),
        .clr_n     (clr_n),
        .req       (s_valid),
        .take      (arb_take),
        .force_vld (acc_pre),
        .force_id  (owner_q[0]),
        .gnt       (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        pend_d    = pend_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        din_d     = din_q;
        key_stb_d = 1'b0;
        confirm_d = 1'b0;
        cancel_d  = 1'b0;
        go_gap    = 1'b0;

        if (acc_own) begin
            if (is_digit(key_own)) begin
                key_stb_d = 1'b1;
                din_d     = key_own;
            end else if (key_own == KEY_CONFIRM) begin
                key_stb_d = 1'b1;
                confirm_d = 1'b1;
            end else if (key_own == KEY_CANCEL) begin
                key_stb_d = 1'b1;
                cancel_d  = 1'b1;
            end
        end else if (acc_pre) begin
            key_stb_d = 1'b1;
            cancel_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (|s_valid) begin
                    owner_d  = arb_gnt;
                    to_cnt_d = '0;
                    state_d  = ST_OWN;
                end
            end
            ST_OWN: begin
                if (to_hit) begin
                    if (!stall_in) begin
                        key_stb_d = 1'b1;
                        cancel_d  = 1'b1;
                    end
                    owner_d = 2'b00;
                    go_gap  = 1'b1;
                end else if (acc_own && is_digit(key_own)) begin
                    to_cnt_d = TO_CREDIT;
                    go_gap   = 1'b1;
                end else if (acc_own && (key_own == KEY_CONFIRM || key_own == KEY_CANCEL)) begin
                    owner_d = 2'b00;
                    go_gap  = 1'b1;
                end else if (acc_pre) begin
                    owner_d = 2'b00;
                    pend_d  = arb_gnt;
                    go_gap  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (owner_q != 2'b00) begin
                        state_d = ST_OWN;
                    end else if (pend_q != 2'b00) begin
                        owner_d  = pend_q;
                        pend_d   = 2'b00;
                        to_cnt_d = '0;
                        state_d  = ST_OWN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_STALL: begin
                if (!stall_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_gap) begin
            if (owner_d == 2'b00) begin
                to_cnt_d = '0;
            end
            if (GAP == 0) begin
                if (owner_d == 2'b00 && pend_d != 2'b00) begin
                    owner_d = pend_d;
                    pend_d  = 2'b00;
                end
                state_d = (owner_d != 2'b00) ? ST_OWN : ST_IDLE;
            end else begin
                state_d   = ST_GAP;
                gap_cnt_d = GW'(GAP - 1);
            end
        end

        // Lock has left keying: drop the session silently, but still forward a key taken this cycle.
        if (stall_in) begin
            state_d   = ST_STALL;
            owner_d   = 2'b00;
            pend_d    = 2'b00;
            to_cnt_d  = '0;
            gap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'b00;
            pend_q    <= 2'b00;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            din_q     <= 4'd0;
            key_stb_q <= 1'b0;
            confirm_q <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            pend_q    <= pend_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            din_q     <= din_d;
            key_stb_q <= key_stb_d;
            confirm_q <= confirm_d;
            cancel_q  <= cancel_d;
        end
    end

    assign key_stb = key_stb_q;
    assign din     = din_q;
    assign confirm = confirm_q;
    assign cancel  = cancel_q;
    assign owner   = owner_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
